quad_enc_gen: RTL and testbench
===============================

// Module: quad_enc_gen
// PURPOSE
//   Quadrature encoder emulator: turns a move command (direction, step count, step period)
//   into a glitch-free SigA/SigB quadrature pair plus a signed position count.
//   Sits on the motor-control FPGA as the stimulus/emulation source for the quadrature
//   decoder/speed-measurement path (loopback self-test, bench motor emulation).
// PARAMETERS
//   PER_W       32   width of cmd_period (clk cycles per quadrature edge)
//   STEP_W      32   width of cmd_steps (number of quadrature edges per move)
//   MIN_PERIOD  2    smallest period honoured; smaller requests are clamped up to it
// PORTS
//   clk          in   1       system clock, all logic on posedge
//   rst_n        in   1       asynchronous active-low reset
//   Clr          in   1       synchronous active-low clear of Pos only
//   cmd_valid    in   1       move command present
//   cmd_ready    out  1       block can accept a command (high exactly in IDLE)
//   cmd_dir      in   1       1 = forward (A leads B), 0 = reverse (B leads A)
//   cmd_steps    in   STEP_W  edges to emit, unsigned
//   cmd_period   in   PER_W   clk cycles between consecutive edges, unsigned
//   abort        in   1       terminate the current move
//   SigA, SigB   out  1       quadrature outputs, registered
//   busy         out  1       move in progress (state RUN)
//   done         out  1       one-cycle pulse on normal completion
//   Pos          out  32      signed edge count, two's complement, registered
// BEHAVIOUR
//   Reset (rst_n low, any time incl. mid-move): SigA=SigB=0, phase=0, Pos=0, busy=0,
//     done=0, timer=0, steps_left=0, state IDLE; takes effect immediately, no edge emitted.
//   Phase: 2-bit index p -> {SigA,SigB}: 0->00, 1->10, 2->11, 3->01. Forward step p+1 mod 4,
//     reverse p-1 mod 4. Exactly one output toggles per step. Forward: A rises while B=0.
//   FSM IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready. Latch dir, steps, and
//     per = max(cmd_period, MIN_PERIOD). steps==0 -> stay IDLE, done pulses next cycle.
//     Otherwise -> RUN with timer=0.
//   FSM RUN: cmd_ready=0, busy=1; timer increments every cycle. When timer==per-1:
//     step phase, Pos +/-1, steps_left-1, timer=0. First edge is per cycles after the
//     accept cycle; later edges are spaced exactly per cycles. Outputs change on the
//     clock after timer==per-1.
//     Edge that brings steps_left to 0 -> IDLE; done=1 for one cycle, in the same
//     cycle SigA/SigB show the final phase. A new command is acceptable one cycle later.
//   abort in RUN: -> IDLE next clock, no further edges, done stays 0, phase/Pos keep their
//     current value. abort on the same cycle as a due edge: abort wins, edge suppressed.
//     abort in IDLE: ignored. Command and abort on the same cycle in IDLE: command accepted.
//   Pos: wraps 0x7FFFFFFF -> 0x80000000 forward, and 0x80000000 -> 0x7FFFFFFF reverse.
//     Clr low: Pos=0 next clock; Clr beats a coincident edge's Pos update (phase still steps).
//   cmd_* are sampled only on the accept cycle; later changes have no effect on the move.
//   timer is PER_W bits; per never below MIN_PERIOD, so timer never wraps.
// STRUCTURE
//   Package quad_pkg: state enum {IDLE,RUN}; 4-entry phase->{A,B} constant table;
//     MIN_PERIOD default. The decoder side shares the table.
//   Sub-module quad_phase_step: 2-bit phase register with step/dir inputs and registered
//     SigA/SigB outputs from the table. The top holds FSM, timer, step counter, Pos.
// TESTING
//   1 fwd: dir=1, steps=8, period=5 -> AB 10,11,01,00 x2; edges 5 cycles apart; first edge
//     5 cycles after accept; Pos=8; one done pulse; busy high 40 cycles.
//   2 rev+clamp: dir=0, steps=4, period=0 -> edges every 2 cycles, AB 01,11,10,00; Pos=-4.
//   3 abort: steps=100, period=10, abort 35 cycles after accept -> exactly 3 edges, Pos=3,
//     no done; coincident abort at an edge cycle -> that edge absent.
//   4 wrap/Clr: Pos preset by Clr then 0x7FFFFFFF fwd steps (forced) -> next edge Pos=0x80000000;
//     Clr low on an edge cycle -> Pos=0 while phase advances.
//   5 reset mid-move: rst_n low mid-RUN -> SigA=SigB=0, Pos=0, busy=0 immediately;
//     steps=0 command -> done pulse, no edges.
//   6 loopback into the quadrature decoder: 1000 fwd steps, period=50 -> decoder
//     count=+1000, direction=forward.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared quadrature definitions: FSM states, phase-to-signal table, period floor.
package quad_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned MIN_PERIOD = 2;

    // Phase index -> {A,B}: 0->00, 1->10, 2->11, 3->01 (Gray sequence, one bit per step)
    localparam logic [3:0][1:0] PHASE_AB = {2'b01, 2'b11, 2'b10, 2'b00};

    function automatic logic [1:0] phase_to_ab(input logic [1:0] p);
        return PHASE_AB[p];
    endfunction

endpackage

// File: rtl/quad_phase_step.sv
// Two-bit quadrature phase register with registered A/B outputs.
module quad_phase_step
    import quad_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    input  logic dir,
    output logic sig_a,
    output logic sig_b
);

    logic [1:0] phase;
    logic [1:0] phase_nxt;

    // Forward walks the table upward, reverse walks it downward
    always_comb begin
        phase_nxt = dir ? (phase + 2'd1) : (phase - 2'd1);
    end

    // Phase advances only on a step; outputs follow from the table in the same clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 2'd0;
            sig_a <= 1'b0;
            sig_b <= 1'b0;
        end else if (step) begin
            phase          <= phase_nxt;
            {sig_a, sig_b} <= phase_to_ab(phase_nxt);
        end
    end

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature encoder emulator: move command -> SigA/SigB edges plus signed position.
module quad_enc_gen
    import quad_pkg::*;
#(
    parameter int unsigned PER_W      = 32,
    parameter int unsigned STEP_W     = 32,
    parameter int unsigned MIN_PERIOD = quad_pkg::MIN_PERIOD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Clr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [PER_W-1:0]  cmd_period,
    input  logic              abort,
    output logic              SigA,
    output logic              SigB,
    output logic              busy,
    output logic              done,
    output logic [31:0]       Pos
);

    localparam int unsigned POS_W = 32;

    state_t              state;
    logic [PER_W-1:0]    timer;
    logic [PER_W-1:0]    per;
    logic [STEP_W-1:0]   steps_left;
    logic                dir_q;
    logic [PER_W-1:0]    per_clamped;
    logic                timer_hit;
    logic                edge_due;

    // Requested period floored to the smallest honoured value
    always_comb begin
        per_clamped = (cmd_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : cmd_period;
    end

    // An edge fires when the interval expires, unless abort cancels it
    always_comb begin
        timer_hit = (state == RUN) && (timer == (per - PER_W'(1)));
        edge_due  = timer_hit && !abort;
    end

    // Move sequencer: accept, pace edges, finish or abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            per        <= PER_W'(MIN_PERIOD);
            steps_left <= '0;
            dir_q      <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dir_q      <= cmd_dir;
                        per        <= per_clamped;
                        steps_left <= cmd_steps;
                        timer      <= '0;
                        if (cmd_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= RUN;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        timer     <= '0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (timer_hit) begin
                        timer      <= '0;
                        steps_left <= steps_left - STEP_W'(1);
                        if (steps_left == STEP_W'(1)) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end else begin
                        timer <= timer + PER_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Signed position; clear takes priority over a coincident edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Pos <= '0;
        end else if (!Clr) begin
            Pos <= '0;
        end else if (edge_due) begin
            Pos <= dir_q ? (Pos + POS_W'(1)) : (Pos - POS_W'(1));
        end
    end

    quad_phase_step u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (edge_due),
        .dir   (dir_q),
        .sig_a (SigA),
        .sig_b (SigB)
    );

endmodule

// File: tb/tb_quad_enc_gen.sv
// Directed bench for quad_enc_gen with an edge scoreboard and a quadrature decoder model.
module tb_quad_enc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Clr = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [31:0] cmd_steps = '0;
    logic [31:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        cmd_ready, SigA, SigB, busy, done;
    logic [31:0] Pos;

    quad_enc_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Clr        (Clr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .SigA       (SigA),
        .SigB       (SigB),
        .busy       (busy),
        .done       (done),
        .Pos        (Pos)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  ab;
        logic [31:0] pos;
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [1:0]  exp_phase = 2'd0;
    logic [31:0] exp_pos = '0;
    logic [1:0]  prev_ab = 2'b00;
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int unsigned last_done = 0;
    int          dec_count = 0;
    logic        dec_fwd = 1'b0;

    function automatic logic [1:0] ab_of(input logic [1:0] p);
        case (p)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] idx_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Edge monitor: scoreboard pop, one-bit-change check, decoder model, done/busy accounting
    always @(negedge clk) begin
        logic [1:0] cur;
        exp_t       e;
        cur = {SigA, SigB};
        if (!rst_n) begin
            prev_ab = cur;
        end else begin
            if (cur != prev_ab) begin
                check("one_toggle", 32'($countones(cur ^ prev_ab)), 32'd1);
                if (idx_of(cur) == idx_of(prev_ab) + 2'd1) begin
                    dec_count++;
                    dec_fwd = 1'b1;
                end else begin
                    dec_count--;
                    dec_fwd = 1'b0;
                end
                if (sb.size() == 0) begin
                    check("spurious_edge", {30'd0, cur}, {30'd0, prev_ab});
                end else begin
                    e = sb.pop_front();
                    check("edge_ab", {30'd0, cur}, {30'd0, e.ab});
                    check("edge_pos", Pos, e.pos);
                    check("edge_cycle", cyc, e.at);
                end
            end
            prev_ab = cur;
            if (done) begin
                done_cnt++;
                last_done = cyc;
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic push_move(input logic dir, input int n, input int unsigned per,
                             input int unsigned acc, input int clr_k);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            exp_phase = dir ? (exp_phase + 2'd1) : (exp_phase - 2'd1);
            if (k == clr_k) exp_pos = '0;
            else            exp_pos = dir ? (exp_pos + 32'd1) : (exp_pos - 32'd1);
            e.ab  = ab_of(exp_phase);
            e.pos = exp_pos;
            e.at  = acc + 32'(k) * per;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic dir, input logic [31:0] steps, input logic [31:0] per,
                        input logic ab, output int unsigned acc);
        @(negedge clk);
        check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_steps  = steps;
        cmd_period = per;
        abort      = ab;
        @(posedge clk);
        #1;
        acc        = cyc;
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        cmd_dir    = ~dir;
        cmd_steps  = $urandom;
        cmd_period = $urandom_range(1, 7);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < maxc);
        if (!cmd_ready) check("idle_timeout", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        Clr = 1'b0;
        @(negedge clk);
        Clr = 1'b1;
        exp_pos = '0;
        check("clr_pos", Pos, 32'd0);
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int unsigned acc;
        int          d0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ab", {30'd0, SigA, SigB}, 32'd0);
        check("rst_pos", Pos, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: forward 8 steps, period 5
        busy_cnt = 0;
        d0 = done_cnt;
        send(1'b1, 32'd8, 32'd5, 1'b0, acc);
        push_move(1'b1, 8, 5, acc, 0);
        check("run_ready", {31'd0, cmd_ready}, 32'd0);
        check("run_busy", {31'd0, busy}, 32'd1);
        wait_idle(100);
        check("t1_pos", Pos, 32'd8);
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t1_done_cycle", last_done, acc + 40);
        check("t1_busy_cycles", 32'(busy_cnt), 32'd40);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // 2: reverse with period clamp; abort alongside command in IDLE is ignored
        clr_pulse();
        send(1'b0, 32'd4, 32'd0, 1'b1, acc);
        push_move(1'b0, 4, 2, acc, 0);
        wait_idle(50);
        check("t2_pos", Pos, 32'hFFFF_FFFC);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 3a: abort 35 cycles after accept -> three edges, no done
        clr_pulse();
        d0 = done_cnt;
        send(1'b1, 32'd100, 32'd10, 1'b0, acc);
        push_move(1'b1, 3, 10, acc, 0);
        wait_cyc(acc + 34);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t3_ready_after_abort", {31'd0, cmd_ready}, 32'd1);
        repeat (30) @(negedge clk);
        check("t3_pos", Pos, 32'd3);
        check("t3_no_done", 32'(done_cnt - d0), 32'd0);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // 3b: abort coincident with a due edge suppresses that edge
        send(1'b1, 32'd100, 32'd4, 1'b0, acc);
        push_move(1'b1, 2, 4, acc, 0);
        wait_cyc(acc + 11);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (12) @(negedge clk);
        check("t3b_pos", Pos, 32'd5);
        check("t3b_busy", {31'd0, busy}, 32'd0);
        check("t3b_sb_empty", 32'(sb.size()), 32'd0);

        // 4: positive wrap, negative wrap, Clr on an edge cycle
        clr_pulse();
        force dut.Pos = 32'h7FFF_FFFF;
        #1;
        release dut.Pos;
        exp_pos = 32'h7FFF_FFFF;
        @(negedge clk);
        check("t4_preset", Pos, 32'h7FFF_FFFF);
        send(1'b1, 32'd1, 32'd3, 1'b0, acc);
        push_move(1'b1, 1, 3, acc, 0);
        wait_idle(20);
        check("t4_wrap_fwd", Pos, 32'h8000_0000);
        send(1'b0, 32'd1, 32'd2, 1'b0, acc);
        push_move(1'b0, 1, 2, acc, 0);
        wait_idle(20);
        check("t4_wrap_rev", Pos, 32'h7FFF_FFFF);
        send(1'b1, 32'd4, 32'd6, 1'b0, acc);
        push_move(1'b1, 4, 6, acc, 2);
        wait_cyc(acc + 11);
        Clr = 1'b0;
        @(negedge clk);
        Clr = 1'b1;
        wait_idle(50);
        check("t4_pos_after_clr", Pos, 32'd2);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);

        // 5: reset mid-move, then zero-step command
        send(1'b1, 32'd10, 32'd3, 1'b0, acc);
        push_move(1'b1, 2, 3, acc, 0);
        wait_cyc(acc + 7);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ab", {30'd0, SigA, SigB}, 32'd0);
        check("t5_rst_pos", Pos, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        exp_phase = 2'd0;
        exp_pos   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        send(1'b1, 32'd0, 32'd5, 1'b0, acc);
        repeat (10) @(negedge clk);
        check("t5_zero_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t5_zero_done_cycle", last_done, acc);
        check("t5_zero_pos", Pos, 32'd0);
        check("t5_zero_busy", {31'd0, busy}, 32'd0);

        // 6: decoder loopback, 1000 forward steps at period 50
        clr_pulse();
        dec_count = 0;
        send(1'b1, 32'd1000, 32'd50, 1'b0, acc);
        push_move(1'b1, 1000, 50, acc, 0);
        wait_idle(52000);
        check("t6_dec_count", 32'(dec_count), 32'd1000);
        check("t6_dec_dir", {31'd0, dec_fwd}, 32'd1);
        check("t6_pos", Pos, 32'd1000);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
